barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 4-bit single-cycle left/right shifter.
- Generalised to WIDTH bits, with logical, arithmetic and rotate modes and a lost-bit flag.
- Uses a valid/ready handshake on both sides so it can sit between streaming datapath blocks under backpressure.
- One log-shifter stage per shift-amount bit, each stage registered.

Parameters:
- WIDTH, 8, data width in bits. Power of two, at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Also equals the pipeline depth L. Derived; do not override.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_shift  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_dir  input  1  0 = left, 1 = right.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_lost  output  1  a 1 bit was discarded by the shift.

Behaviour:
- Reset: on the clk edge with rst=1, all stage valid bits, out_valid, out_data and out_lost clear to 0. in_ready is then 1.
- Reset mid-operation: all in-flight beats are discarded, none emitted. rst takes priority over every other input.
- Pipeline structure: L = SHAMT_W stages. Stage k conditionally shifts by 2^k when in_shift[k]=1. Stage k-1 feeds stage k. The last stage register drives out_*.
- Each stage carries: valid, data, remaining shift bits, dir, mode, and an accumulated lost flag.
- Advance enable: adv = out_ready | ~out_valid. in_ready = adv; it is combinational and depends only on out_ready and out_valid.
- Stall behaviour: when adv=1, every stage loads from its predecessor, stage 0 loads from the in_* ports, and bubbles propagate as valid=0. When adv=0, all stages hold.
- Input handshake: a beat is accepted when in_valid & in_ready.
- Output handshake: a beat is consumed when out_valid & out_ready.
- out_data and out_lost are stable while out_valid=1 and out_ready=0.
- Latency: exactly L cycles from acceptance to out_valid, with no stalls. WIDTH=8 gives 3 cycles.
- Throughput: one beat per cycle while out_ready=1. Beats are emitted in order, none dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal and required.
- Logical mode (00): vacated bits are filled with 0.
- Arithmetic mode (01):
  - Right shift fills vacated bits with the original MSB (in_data[WIDTH-1]), captured at stage 0 and carried along.
  - Left shift is identical to logical left.
- Rotate mode (10): bits shifted out re-enter at the opposite end. out_lost is always 0.
- Reserved mode (11): out_data = in_data regardless of shift or dir, and out_lost=0. This is a defined pass-through, not X.
- out_lost in modes 00/01: OR of all bits that leave the word across all stages.
- Shift amount 0: out_data = in_data, out_lost=0, in every mode.
- Maximum shift is WIDTH-1. No amount can reach WIDTH, so a full shift-out is impossible.
- Arithmetic right shift by WIDTH-1 yields all copies of the MSB.
- Width rules: all internal arithmetic is WIDTH bits. There is no carry-out beyond out_lost.

Test Plan:
All cases use WIDTH=8 and in_data=0xB4 (1011_0100).
- Logical left: mode=00, dir=0, shift=3 -> out_data=0xA0, out_lost=1. out_valid rises exactly 3 cycles after accept, with out_ready held at 1.
- Arithmetic right: mode=01, dir=1, shift=2 -> out_data=0xED, out_lost=0.
  - Same operation on 0x34 -> 0x0D, out_lost=0.
  - Shift=7 on 0xB4 -> 0xFF, out_lost=1.
- Rotate: mode=10.
  - dir=0, shift=3 -> 0xA5, out_lost=0.
  - dir=1, shift=1 -> 0x5A, out_lost=0.
  - Logical right shift=2 -> 0x2D, out_lost=0.
- Reserved and zero shift:
  - mode=11, shift=5, dir=1 -> 0xB4, out_lost=0.
  - mode=00, shift=0 -> 0xB4, out_lost=0.
- Backpressure:
  - Stream 5 back-to-back beats with shift=1, dir=0, mode=00 and data 0x01..0x05.
  - Hold out_ready=0 from cycle 4 for 3 cycles, then release.
  - Required: in_ready=0 while out_valid=1 and out_ready=0. Outputs 0x02,0x04,0x06,0x08,0x0A appear in order, none lost or duplicated, and out_data is held stable while stalled.
- Reset mid-stream:
  - Accept 2 beats, assert rst for 1 cycle before either emerges.
  - Required: out_valid=0 the cycle after reset, and the two beats are never emitted.
  - A new beat accepted after reset appears 3 cycles later with the correct value.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// Stream interface for the pipelined barrel shifter.
// Carries the operand beat in and the shifted result beat out.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shift;
  logic               in_dir;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_lost;

  modport master (
    output in_valid, in_data, in_shift,
    output in_dir, in_mode, out_ready,
    input  in_ready, out_valid,
    input  out_data, out_lost
  );

  modport slave (
    input  in_valid, in_data, in_shift,
    input  in_dir, in_mode, out_ready,
    output in_ready, out_valid,
    output out_data, out_lost
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter, one registered stage per shift bit.
// Logical, arithmetic, rotate and pass-through modes with lost-bit flag.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  barrel_shifter_pipe_if.slave bus
);

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] sh;
    logic               dir;
    logic [1:0]         mode;
    logic               msb;
    logic               lost;
  } stage_t;

  function automatic stage_t step(
    input stage_t s,
    input int     k
  );
    stage_t           o;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    int               n;
    o    = s;
    ones = '1;
    n    = 1 << k;
    lo   = ~(ones << n);
    hi   = ~(ones >> n);
    if (s.sh[k] && (s.mode != MODE_RSV)) begin
      if (s.mode == MODE_ROT) begin
        if (s.dir)
          o.data = (s.data >> n)
                 | (s.data << (WIDTH - n));
        else
          o.data = (s.data << n)
                 | (s.data >> (WIDTH - n));
      end else if (s.dir) begin
        o.data = s.data >> n;
        if ((s.mode == MODE_ARI) && s.msb)
          o.data = o.data | hi;
        o.lost = s.lost | (|(s.data & lo));
      end else begin
        o.data = s.data << n;
        o.lost = s.lost | (|(s.data & hi));
      end
    end
    return o;
  endfunction

  logic   adv;
  stage_t src0;
  stage_t last;

  assign adv          = bus.out_ready | ~last.valid;
  assign bus.in_ready = adv;

  // Build the stage-0 input bundle; the sign bit rides along for ASR.
  always_comb begin
    src0       = '0;
    src0.valid = bus.in_valid;
    src0.data  = bus.in_data;
    src0.sh    = bus.in_shift;
    src0.dir   = bus.in_dir;
    src0.mode  = bus.in_mode;
    src0.msb   = bus.in_data[WIDTH-1];
    src0.lost  = 1'b0;
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_st
    stage_t prev;
    stage_t r;

    if (k == 0) begin : g_first
      assign prev = src0;
    end else begin : g_next
      assign prev = g_st[k-1].r;
    end

    // One shift-by-2^k step; the whole pipe advances or holds together.
    always_ff @(posedge clk) begin
      if (rst)
        r <= '0;
      else if (adv)
        r <= step(prev, k);
    end
  end

  assign last          = g_st[SHAMT_W-1].r;
  assign bus.out_valid = last.valid;
  assign bus.out_data  = last.data;
  assign bus.out_lost  = last.lost;

  logic unused_tail;
  assign unused_tail = ^{last.sh, last.dir,
                         last.mode, last.msb};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=8.
// Driver pushes expected beats on accept; monitor pops on emit.
module tb_barrel_shifter_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    bit           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  barrel_shifter_pipe_if #(.WIDTH(W)) bus ();

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [W-1:0] d,
                      input logic [2:0]   sh,
                      input logic         dr,
                      input logic [1:0]   md,
                      input logic [W-1:0] ed,
                      input logic         el,
                      input bit           lat);
    bit   done;
    int   n;
    exp_t e;
    done = 0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = sh;
    bus.in_dir   = dr;
    bus.in_mode  = md;
    while (!done) begin
      #4;
      if (bus.in_ready) begin
        e.d = ed;
        e.l = el;
        e.lat = lat;
        e.acc = cyc;
        exp_q.push_back(e);
        done = 1;
      end
      @(negedge clk);
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout waited %0d want <=200", n);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] held_d;
  logic         held_l;
  bit           held_v = 0;

  // Monitor: sample just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst || !bus.out_valid) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("stall_data", bus.out_data, held_d);
          chk("stall_lost", bus.out_lost, held_l);
        end
        if (!bus.out_ready) begin
          chk("in_ready_stall", bus.in_ready, 0);
          held_v = 1;
          held_d = bus.out_data;
          held_l = bus.out_lost;
        end else begin
          held_v = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got %0h want none",
                     bus.out_data);
          end else begin
            checks--;
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.d);
            chk("out_lost", bus.out_lost, e.l);
            if (e.lat)
              chk("latency", cyc - e.acc, 3);
          end
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog cycles %0d want <50000", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.in_dir    = 1'b0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_lost", bus.out_lost, 0);
    @(negedge clk);

    send(8'hB4, 3, 0, 2'b00, 8'hA0, 1, 1);
    drain();
    send(8'hB4, 2, 1, 2'b01, 8'hED, 0, 1);
    send(8'h34, 2, 1, 2'b01, 8'h0D, 0, 1);
    send(8'hB4, 7, 1, 2'b01, 8'hFF, 1, 1);
    send(8'hB4, 3, 0, 2'b10, 8'hA5, 0, 1);
    send(8'hB4, 1, 1, 2'b10, 8'h5A, 0, 1);
    send(8'hB4, 2, 1, 2'b00, 8'h2D, 0, 1);
    send(8'hB4, 3, 1, 2'b00, 8'h16, 1, 1);
    send(8'hB4, 3, 0, 2'b01, 8'hA0, 1, 1);
    send(8'hB4, 5, 1, 2'b11, 8'hB4, 0, 1);
    send(8'hB4, 0, 0, 2'b00, 8'hB4, 0, 1);
    send(8'hB4, 0, 1, 2'b01, 8'hB4, 0, 1);
    drain();

    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(W'(i), 1, 0, 2'b00, W'(2 * i), 0, 0);
      end
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    send(8'h11, 1, 0, 2'b00, 8'h22, 0, 0);
    send(8'h12, 1, 0, 2'b00, 8'h24, 0, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("post_rst_valid", bus.out_valid, 0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    send(8'h55, 1, 0, 2'b00, 8'hAA, 0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
